// File: rtl/hnoc_pkg.sv
// Shared definitions for HNoC processing-element traffic generation and checking:
// flit field layout, LFSR polynomial/seed, generator state encoding and
// small pure helpers that both the transmit and receive sides rely on.
package hnoc_pkg;

   // Flit layout: [31:30] dst, [29:28] src, [27:16] seq, [15:0] payload
   localparam int FLIT_W    = 32;
   localparam int FIELD_W   = 2;
   localparam int DST_LSB   = 30;
   localparam int SRC_LSB   = 28;
   localparam int SEQ_LSB   = 16;
   localparam int SEQ_W     = 12;
   localparam int PAYLOAD_W = 16;

   // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } gen_state_e;

   // One Fibonacci step: shift toward the MSB, parity of the tapped bits enters bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {state[14:0], ^(state & LFSR_TAPS)};
   endfunction

   // Destination from the low LFSR bits, folded onto the PE count; a PE never
   // targets itself, so a self-hit is pushed to the next address round-robin.
   function automatic logic [FIELD_W-1:0] pick_dst(
      input logic [FIELD_W-1:0] lfsr_low,
      input logic [FIELD_W-1:0] src,
      input logic [FIELD_W-1:0] pe_mask
   );
      logic [FIELD_W-1:0] dst;
      dst = lfsr_low & pe_mask;
      if (dst == src) begin
         dst = (src + 2'd1) & pe_mask;
      end
      return dst;
   endfunction

   // Assemble a flit from its fields.
   function automatic logic [FLIT_W-1:0] pack_flit(
      input logic [FIELD_W-1:0]   dst,
      input logic [FIELD_W-1:0]   src,
      input logic [SEQ_W-1:0]     seq,
      input logic [PAYLOAD_W-1:0] payload
   );
      logic [FLIT_W-1:0] flit;
      flit = '0;
      flit[DST_LSB +: FIELD_W]  = dst;
      flit[SRC_LSB +: FIELD_W]  = src;
      flit[SEQ_LSB +: SEQ_W]    = seq;
      flit[0 +: PAYLOAD_W]      = payload;
      return flit;
   endfunction

endpackage

// File: rtl/pe_traffic_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when asked. Shared by the packet
// generator and the receive-side checker so both walk the same payload sequence.
module lfsr16
   import hnoc_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_step,
   output logic [15:0] o_state
);

   // An all-zero state would lock the register up, so a zero seed falls back to the default.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

   logic [15:0] state_reg;

   // Hold the state until a step request, restart from the seed on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= SEED_EFF;
      end else if (i_step) begin
         state_reg <= lfsr_next(state_reg);
      end
   end

   assign o_state = state_reg;

endmodule

// File: rtl/pe_traffic_gen.sv
// Single-flit packet generator for one HNoC PE port. Emits self-describing flits
// (dst, src, seq, LFSR payload) under a valid/ready handshake, with an optional
// packet limit and inter-packet gap. All outputs come straight from registers.
module pe_traffic_gen
   import hnoc_pkg::*;
#(
   parameter int          ADDRESS   = 0,
   parameter int          NUM_PES   = 4,
   parameter int          PKT_LIMIT = 16,
   parameter int          GAP       = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,
   output logic [31:0] o_data,
   output logic        o_data_valid,
   input  logic        i_data_ready,
   output logic [31:0] o_sent_count,
   output logic        o_done
);

   localparam logic [FIELD_W-1:0] SRC      = FIELD_W'(ADDRESS);
   // NUM_PES is 2 or 4, so modulo reduces to a mask of the low address bits.
   localparam logic [FIELD_W-1:0] PE_MASK  = FIELD_W'(NUM_PES - 1);
   localparam logic [31:0]        LIMIT    = 32'(PKT_LIMIT);
   // WAIT counts down to zero, so it is loaded with one less than the gap length.
   localparam logic [31:0]        GAP_LOAD = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

   gen_state_e          state_reg;
   gen_state_e          state_next;
   logic                valid_reg;
   logic                done_reg;
   logic [FLIT_W-1:0]   data_reg;
   logic [FLIT_W-1:0]   data_next;
   logic [31:0]         count_reg;
   logic [31:0]         count_next;
   logic [SEQ_W-1:0]    seq_reg;
   logic [SEQ_W-1:0]    seq_next;
   logic [31:0]         gap_cnt_reg;
   logic [31:0]         gap_cnt_next;
   logic [15:0]         lfsr_state;
   logic [15:0]         lfsr_after;
   logic                transfer;
   logic                limit_hit;

   // Payload source; steps exactly once per accepted flit.
   lfsr16 #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .i_step  (transfer),
      .o_state (lfsr_state)
   );

   // Handshake and the values the counters/LFSR will hold after this edge.
   always_comb begin
      transfer   = valid_reg && i_data_ready;
      count_next = count_reg + 32'(transfer);
      seq_next   = seq_reg + SEQ_W'(transfer);
      lfsr_after = transfer ? lfsr_next(lfsr_state) : lfsr_state;
      limit_hit  = (PKT_LIMIT != 0) && (count_next == LIMIT);
   end

   // Next-state logic; i_enable only matters in IDLE and when a gap expires.
   always_comb begin
      state_next   = state_reg;
      gap_cnt_next = gap_cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (i_enable) begin
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (transfer) begin
               if (limit_hit) begin
                  state_next = ST_DONE;
               end else if (GAP == 0) begin
                  state_next = ST_SEND;
               end else begin
                  state_next   = ST_WAIT;
                  gap_cnt_next = GAP_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (gap_cnt_reg == 32'd0) begin
               state_next = i_enable ? ST_SEND : ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg - 32'd1;
            end
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The flit register is rebuilt whenever the next cycle presents a flit. While
   // back-pressured nothing advances, so the rebuilt value equals the held one.
   always_comb begin
      data_next = data_reg;
      if (state_next == ST_SEND) begin
         data_next = pack_flit(pick_dst(lfsr_after[FIELD_W-1:0], SRC, PE_MASK),
                               SRC, seq_next, lfsr_after);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Registered outputs, counters and gap timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg   <= 1'b0;
         done_reg    <= 1'b0;
         data_reg    <= '0;
         count_reg   <= 32'd0;
         seq_reg     <= '0;
         gap_cnt_reg <= 32'd0;
      end else begin
         valid_reg   <= (state_next == ST_SEND);
         done_reg    <= (state_next == ST_DONE);
         data_reg    <= data_next;
         count_reg   <= count_next;
         seq_reg     <= seq_next;
         gap_cnt_reg <= gap_cnt_next;
      end
   end

   assign o_data       = data_reg;
   assign o_data_valid = valid_reg;
   assign o_sent_count = count_reg;
   assign o_done       = done_reg;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Scoreboard bench for pe_traffic_gen: four generators with different
// parameters. Stimulus pushes the flits a model predicts; a negedge monitor
// pops and compares on every handshake and watches hold/reset/count/done.
module tb_pe_traffic_gen;

   localparam int N_DUT = 4;
   localparam int          ADDR_P [N_DUT] = '{0, 1, 2, 0};
   localparam int          NPES_P [N_DUT] = '{4, 4, 4, 2};
   localparam int          LIM_P  [N_DUT] = '{4, 4, 3, 0};
   localparam int          GAP_P  [N_DUT] = '{0, 0, 3, 0};
   localparam logic [15:0] SEED_P [N_DUT] = '{16'hACE1, 16'hACE1, 16'h1234, 16'h0000};

   logic        clk;
   logic        rst_w   [N_DUT];
   logic        en_w    [N_DUT];
   logic        ready_w [N_DUT];
   logic        valid_w [N_DUT];
   logic        done_w  [N_DUT];
   logic [31:0] data_w  [N_DUT];
   logic [31:0] count_w [N_DUT];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < N_DUT; gi++) begin : g_dut
         pe_traffic_gen #(
            .ADDRESS   (ADDR_P[gi]),
            .NUM_PES   (NPES_P[gi]),
            .PKT_LIMIT (LIM_P[gi]),
            .GAP       (GAP_P[gi]),
            .LFSR_SEED (SEED_P[gi])
         ) u_dut (
            .clk          (clk),
            .rst          (rst_w[gi]),
            .i_enable     (en_w[gi]),
            .o_data       (data_w[gi]),
            .o_data_valid (valid_w[gi]),
            .i_data_ready (ready_w[gi]),
            .o_sent_count (count_w[gi]),
            .o_done       (done_w[gi])
         );
      end
   endgenerate

   // ---------------- scoreboard and reference model ----------------
   logic [31:0] exp_q [N_DUT][$];
   logic [15:0] m_lfsr [N_DUT];
   int          m_seq  [N_DUT];
   bit          rand_ready [N_DUT];
   int          arm_seq [N_DUT] = '{default: 0};
   bit          final_req = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [15:0] model_seed(input int i);
      return (SEED_P[i] == 16'h0000) ? 16'hACE1 : SEED_P[i];
   endfunction

   // Polynomial x^16+x^14+x^13+x^11+1: feedback is the XOR of the bits at
   // exponent-1 for each non-constant term; new bit enters at the bottom.
   function automatic logic [15:0] model_step(input logic [15:0] s);
      int taps [4];
      int fb;
      taps = '{16, 14, 13, 11};
      fb = 0;
      for (int k = 0; k < 4; k++) fb = fb ^ ((int'(s) >> (taps[k] - 1)) & 1);
      return 16'(((int'(s) * 2) + fb) % 65536);
   endfunction

   function automatic logic [31:0] model_flit(input int i, input logic [15:0] s, input int seq);
      int dst;
      dst = int'(s) % NPES_P[i];
      if (dst == ADDR_P[i]) dst = (ADDR_P[i] + 1) % NPES_P[i];
      return (32'(dst) << 30) | (32'(ADDR_P[i]) << 28) | (32'(seq) << 16) | 32'(s);
   endfunction

   task automatic model_reset(input int i);
      m_lfsr[i] = model_seed(i);
      m_seq[i]  = 0;
      exp_q[i].delete();
   endtask

   task automatic push_run(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         exp_q[i].push_back(model_flit(i, m_lfsr[i], m_seq[i]));
         m_lfsr[i] = model_step(m_lfsr[i]);
         m_seq[i]  = (m_seq[i] + 1) % 4096;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N_DUT; i++) begin
         if (rand_ready[i]) ready_w[i] = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic enable_pulse(input int i);
      en_w[i] = 1'b1;
      arm_seq[i] = arm_seq[i] + 1;
      tick();
      en_w[i] = 1'b0;
   endtask

   // ---------------- monitor ----------------
   int          cyc = 0;
   int          m_cnt       [N_DUT] = '{default: 0};
   bit          prev_rst    [N_DUT];
   bit          hold_pend   [N_DUT];
   logic [31:0] hold_data   [N_DUT];
   int          lat_ack     [N_DUT] = '{default: 0};
   int          lat_n       [N_DUT] = '{default: 0};
   int          last_cyc    [N_DUT] = '{default: 0};
   bit          have_last   [N_DUT];
   bit          clean       [N_DUT];
   bit          final_done = 1'b0;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%08h, want 0x%08h", name, idx, act, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [31:0] expv;
      bit          exp_done;
      cyc <= cyc + 1;
      for (int i = 0; i < N_DUT; i++) begin
         exp_done = (LIM_P[i] != 0) && (m_cnt[i] >= LIM_P[i]);
         if (prev_rst[i]) begin
            check("reset_valid", i, 32'(valid_w[i]), 32'd0);
            check("reset_data", i, data_w[i], 32'd0);
         end
         check("sent_count", i, count_w[i], 32'(m_cnt[i]));
         check("done", i, 32'(done_w[i]), 32'(exp_done));
         if (exp_done) check("valid_after_done", i, 32'(valid_w[i]), 32'd0);
         if (hold_pend[i] && !prev_rst[i]) begin
            check("hold_valid", i, 32'(valid_w[i]), 32'd1);
            check("hold_data", i, data_w[i], hold_data[i]);
         end
         if (arm_seq[i] != lat_ack[i]) begin
            if (lat_n[i] == 0) begin
               check("start_latency_low", i, 32'(valid_w[i]), 32'd0);
               lat_n[i] <= 1;
            end else begin
               check("start_latency_high", i, 32'(valid_w[i]), 32'd1);
               lat_n[i]   <= 0;
               lat_ack[i] <= arm_seq[i];
            end
         end
         if (!ready_w[i] || (GAP_P[i] > 0 && !en_w[i])) clean[i] <= 1'b0;

         if (rst_w[i]) begin
            m_cnt[i]     <= 0;
            hold_pend[i] <= 1'b0;
            have_last[i] <= 1'b0;
         end else if (valid_w[i] && ready_w[i]) begin
            $display("dut%0d xfer #%0d flit 0x%08h", i, m_cnt[i], data_w[i]);
            if (exp_q[i].size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_flit dut%0d: got 0x%08h, want no flit", i, data_w[i]);
            end else begin
               expv = exp_q[i].pop_front();
               check("flit", i, data_w[i], expv);
            end
            check("dst_not_self", i, 32'(data_w[i][31:30] != 2'(ADDR_P[i])), 32'd1);
            if (m_cnt[i] == 0 && i == 0) check("first_flit", i, data_w[i], 32'h4000ACE1);
            if (m_cnt[i] == 0 && i == 1) check("first_flit", i, data_w[i], 32'h9000ACE1);
            if (have_last[i] && clean[i]) check("flit_interval", i, 32'(cyc - last_cyc[i]), 32'(GAP_P[i] + 1));
            have_last[i] <= 1'b1;
            last_cyc[i]  <= cyc;
            clean[i]     <= 1'b1;
            m_cnt[i]     <= m_cnt[i] + 1;
            hold_pend[i] <= 1'b0;
         end else if (valid_w[i]) begin
            hold_pend[i] <= 1'b1;
            hold_data[i] <= data_w[i];
         end else begin
            hold_pend[i] <= 1'b0;
         end
         prev_rst[i] <= rst_w[i];
      end
      if (final_req && !final_done) begin
         for (int i = 0; i < N_DUT; i++) check("leftover_flits", i, 32'(exp_q[i].size()), 32'd0);
         final_done <= 1'b1;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < N_DUT; i++) begin
         rst_w[i] = 1'b1;
         en_w[i] = 1'b0;
         ready_w[i] = 1'b0;
         rand_ready[i] = 1'b0;
         model_reset(i);
      end
      ticks(3);
      for (int i = 0; i < N_DUT; i++) rst_w[i] = 1'b0;
      ticks(2);

      // dut0: enable pulse, ready high -> four back-to-back flits, then done
      ready_w[0] = 1'b1;
      push_run(0, 4);
      enable_pulse(0);
      ticks(10);
      rst_w[0] = 1'b1; model_reset(0); tick(); rst_w[0] = 1'b0; tick();

      // dut0: first flit back-pressured for 20+ cycles
      ready_w[0] = 1'b0;
      push_run(0, 4);
      enable_pulse(0);
      ticks(22);
      ready_w[0] = 1'b1;
      ticks(8);
      rst_w[0] = 1'b1; model_reset(0); tick(); rst_w[0] = 1'b0; tick();

      // dut0: reset while a flit is presented and stalled; restart from seq 0
      ready_w[0] = 1'b0;
      push_run(0, 4);
      enable_pulse(0);
      ticks(3);
      rst_w[0] = 1'b1; model_reset(0); tick(); rst_w[0] = 1'b0; ticks(2);
      push_run(0, 4);
      enable_pulse(0);
      ready_w[0] = 1'b1;
      ticks(10);

      // dut1: ADDRESS=1 with random back-pressure
      rand_ready[1] = 1'b1;
      en_w[1] = 1'b1;
      push_run(1, 4);
      arm_seq[1] = arm_seq[1] + 1;
      ticks(40);
      en_w[1] = 1'b0;
      rand_ready[1] = 1'b0;
      ready_w[1] = 1'b0;

      // dut2: GAP=3, limit 3
      ready_w[2] = 1'b1;
      en_w[2] = 1'b1;
      push_run(2, 3);
      arm_seq[2] = arm_seq[2] + 1;
      ticks(25);
      en_w[2] = 1'b0;

      // dut3: unlimited, zero seed, 4100 flits across the seq wrap
      rand_ready[3] = 1'b1;
      en_w[3] = 1'b1;
      push_run(3, 4100);
      arm_seq[3] = arm_seq[3] + 1;
      begin
         int n;
         n = 0;
         while (exp_q[3].size() != 0 && n < 9000) begin
            tick();
            n++;
         end
      end
      rand_ready[3] = 1'b0;
      ready_w[3] = 1'b0;
      ticks(5);

      final_req = 1'b1;
      ticks(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
